// File: rtl/stack_alu_sequencer_if.sv
// Opcode/result bus between the stack-ALU sequencer (master) and the stack ALU (slave).
interface stack_alu_sequencer_if #(
  parameter int N = 4
);
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data;
  logic [N-1:0] alu_result;
  logic         alu_overflow;

  modport master (
    output alu_opcode,
    output alu_data,
    input  alu_result,
    input  alu_overflow
  );

  modport slave (
    input  alu_opcode,
    input  alu_data,
    output alu_result,
    output alu_overflow
  );
endinterface

// File: rtl/stack_alu_sequencer.sv
// Issues a loaded (opcode, data) program to a stack ALU one per cycle and captures its results.
// Optional HALT_ON_OVF_EN: a captured overflowing result stops further issue.
module stack_alu_sequencer #(
  parameter int N      = 4,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int SDEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we_i,
  input  logic [AW-1:0]         prog_addr_i,
  input  logic [2:0]            prog_op_i,
  input  logic [N-1:0]          prog_data_i,
  input  logic [AW:0]           prog_len_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  res_valid_o,
  output logic [N-1:0]          res_data_o,
  output logic                  res_ovf_o,
  output logic                  err_o,
  stack_alu_sequencer_if.master alu
);

  localparam int DW = $clog2(SDEPTH + 1);
  localparam logic [DW-1:0] SD_MAX = DW'(SDEPTH);
  localparam logic [DW-1:0] D_TWO  = DW'(2);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   ip_q;
  logic [AW:0]     len_q;
  logic [DW-1:0]   depth_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [2:0]      op_q;
  logic [N-1:0]    data_q;
  logic [1:0]      exp_q;
  logic            res_valid_q;
  logic [N-1:0]    res_data_q;
  logic            res_ovf_q;

  logic [2:0]      mem_op   [DEPTH];
  logic [N-1:0]    mem_data [DEPTH];

  logic [2:0]      cur_op;
  logic [N-1:0]    cur_dat;
  logic            legal;
  logic            yields;
  logic [DW-1:0]   depth_d;
  logic            last_issue;
  logic            halt;
  logic            issue_res;

  // Program memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (prog_we_i && !busy_q) begin
      mem_op[prog_addr_i]   <= prog_op_i;
      mem_data[prog_addr_i] <= prog_data_i;
    end
  end

  // Legality is judged against the local mirror of the ALU stack depth.
  always_comb begin
    cur_op  = mem_op[ip_q];
    cur_dat = mem_data[ip_q];
    legal   = 1'b1;
    yields  = 1'b0;
    depth_d = depth_q;
    case (cur_op)
      OP_PUSH: begin
        if (depth_q < SD_MAX) depth_d = depth_q + 1'b1;
        else                  legal   = 1'b0;
      end
      OP_POP: begin
        if (depth_q >= D_TWO) begin
          depth_d = depth_q - 1'b1;
          yields  = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_ADD, OP_MUL: begin
        if (depth_q >= D_TWO) yields = 1'b1;
        else                  legal  = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef HALT_ON_OVF_EN
  assign halt = res_valid_q & res_ovf_q;
`else
  assign halt = 1'b0;
`endif

  assign last_issue = ({1'b0, ip_q} == (len_q - 1'b1));
  assign issue_res  = (state_q == S_RUN) && !halt && legal && yields;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ip_q        <= '0;
      len_q       <= '0;
      depth_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= OP_NOP;
      data_q      <= '0;
      exp_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      op_q        <= OP_NOP;
      data_q      <= '0;
      exp_q       <= {exp_q[0], issue_res};
      // exp_q[1] marks an ALU result that is valid on the bus this cycle.
      res_valid_q <= exp_q[1];
      if (exp_q[1]) begin
        res_data_q <= alu.alu_result;
        res_ovf_q  <= alu.alu_overflow;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_q  <= 1'b0;
            ip_q   <= '0;
            len_q  <= prog_len_i;
            busy_q <= 1'b1;
            if (prog_len_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (halt) begin
            state_q <= S_DRAIN;
          end else begin
            if (legal) begin
              op_q    <= cur_op;
              data_q  <= cur_dat;
              depth_q <= depth_d;
            end else begin
              err_q <= 1'b1;
            end
            ip_q <= ip_q + 1'b1;
            if (last_issue) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The last pending capture lands on the same edge that enters DONE.
          if (!exp_q[0]) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu.alu_opcode = op_q;
  assign alu.alu_data   = data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign res_valid_o    = res_valid_q;
  assign res_data_o     = res_data_q;
  assign res_ovf_o      = res_ovf_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Randomized and directed bench for stack_alu_sequencer with a behavioural stack ALU and program-level reference model.
module tb_stack_alu_sequencer;
  localparam int N      = 4;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int SDEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we_i;
  logic [AW-1:0] prog_addr_i;
  logic [2:0]    prog_op_i;
  logic [N-1:0]  prog_data_i;
  logic [AW:0]   prog_len_i;
  logic          start_i;
  logic          busy_o, done_o, res_valid_o, res_ovf_o, err_o;
  logic [N-1:0]  res_data_o;

  int errors = 0;
  int checks = 0;

  stack_alu_sequencer_if #(.N(N)) alu_if ();

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH), .AW(AW), .SDEPTH(SDEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_op_i   (prog_op_i),
    .prog_data_i (prog_data_i),
    .prog_len_i  (prog_len_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .res_valid_o (res_valid_o),
    .res_data_o  (res_data_o),
    .res_ovf_o   (res_ovf_o),
    .err_o       (err_o),
    .alu         (alu_if)
  );

  always #5 clk = ~clk;

  // Stand-in stack ALU: registered result one edge after the opcode is presented.
  int alu_stk[$];
  int alu_a, alu_b, alu_s;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_stk.delete();
      alu_if.alu_result   <= '0;
      alu_if.alu_overflow <= 1'b0;
    end else begin
      case (alu_if.alu_opcode)
        3'b110: if (alu_stk.size() < SDEPTH) alu_stk.push_back(int'($signed(alu_if.alu_data)));
        3'b111: if (alu_stk.size() >= 2) begin
          alu_s = alu_stk.pop_back();
          alu_if.alu_result   <= alu_s[N-1:0];
          alu_if.alu_overflow <= 1'b0;
        end
        3'b100, 3'b101: if (alu_stk.size() >= 2) begin
          alu_a = alu_stk[alu_stk.size()-1];
          alu_b = alu_stk[alu_stk.size()-2];
          alu_s = (alu_if.alu_opcode == 3'b100) ? alu_a + alu_b : alu_a * alu_b;
          alu_if.alu_result   <= alu_s[N-1:0];
          alu_if.alu_overflow <= (alu_s > 7) || (alu_s < -8);
        end
        default: ;
      endcase
    end
  end

  // Program image and program-level reference model.
  logic [2:0]   p_op  [DEPTH];
  logic [N-1:0] p_dat [DEPTH];
  int ref_stk[$];
  int exp_op [DEPTH];
  int n_issue;
  int exp_err;
  int exp_rdat[$], exp_rovf[$], exp_rcyc[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_run(input int len);
    int halt_at;
    halt_at = 1 << 30;
    exp_rdat.delete();
    exp_rovf.delete();
    exp_rcyc.delete();
    n_issue = 0;
    exp_err = 0;
    for (int i = 0; i < len; i++) begin
      int a, b, s, ovf;
      bit legal, yields;
      if (i >= halt_at) break;
      legal  = 1'b1;
      yields = 1'b0;
      s      = 0;
      ovf    = 0;
      case (p_op[i])
        3'b110: begin
          if (ref_stk.size() < SDEPTH) ref_stk.push_back(int'($signed(p_dat[i])));
          else legal = 1'b0;
        end
        3'b111: begin
          if (ref_stk.size() >= 2) begin
            s = ref_stk.pop_back();
            yields = 1'b1;
          end else legal = 1'b0;
        end
        3'b100, 3'b101: begin
          if (ref_stk.size() >= 2) begin
            a = ref_stk[ref_stk.size()-1];
            b = ref_stk[ref_stk.size()-2];
            s = (p_op[i] == 3'b100) ? a + b : a * b;
            ovf = ((s > 7) || (s < -8)) ? 1 : 0;
            yields = 1'b1;
          end else legal = 1'b0;
        end
        default: ;
      endcase
      exp_op[i] = legal ? int'(p_op[i]) : 0;
      if (!legal) exp_err = 1;
      if (yields) begin
        exp_rdat.push_back(s & ((1 << N) - 1));
        exp_rovf.push_back(ovf);
        exp_rcyc.push_back(i + 3);
`ifdef HALT_ON_OVF_EN
        if (ovf != 0 && i + 3 < halt_at) halt_at = i + 3;
`endif
      end
      n_issue = i + 1;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) begin
      p_op[i]  = 3'b000;
      p_dat[i] = '0;
    end
  endtask

  task automatic setp(input int i, input logic [2:0] op, input int d);
    p_op[i]  = op;
    p_dat[i] = d[N-1:0];
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      prog_we_i   = 1'b1;
      prog_addr_i = i[AW-1:0];
      prog_op_i   = p_op[i];
      prog_data_i = p_dat[i];
    end
    @(negedge clk);
    prog_we_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_stk.delete();
  endtask

  task automatic run_prog(input int len, input bit reload, input string name);
    int obs_op [64];
    int rd[$], ro[$], rc[$];
    int done_cyc, last;
    if (reload) load_prog();
    model_run(len);
    done_cyc = -1;
    @(negedge clk);
    start_i    = 1'b1;
    prog_len_i = len[AW:0];
    @(negedge clk);
    start_i = 1'b0;
    chk($sformatf("%s.busy", name), int'(busy_o), 1);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      // A write while busy must not reach program memory.
      if (cyc == 1 && len > 0) begin
        prog_we_i   = 1'b1;
        prog_addr_i = '0;
        prog_op_i   = 3'b111;
        prog_data_i = '1;
      end
      if (cyc == 2) prog_we_i = 1'b0;
      obs_op[cyc] = int'(alu_if.alu_opcode);
      if (res_valid_o) begin
        rd.push_back(int'(res_data_o));
        ro.push_back(int'(res_ovf_o));
        rc.push_back(cyc);
      end
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
    end
    prog_we_i = 1'b0;
    last = (done_cyc < 0) ? 59 : done_cyc;
    chk($sformatf("%s.done_seen", name), int'(done_cyc >= 0), 1);
    for (int i = 0; i < n_issue; i++)
      chk($sformatf("%s.op%0d", name, i), obs_op[i+1], exp_op[i]);
    if (n_issue + 1 <= last)
      chk($sformatf("%s.op_after", name), obs_op[n_issue+1], 0);
    chk($sformatf("%s.nres", name), rd.size(), exp_rdat.size());
    for (int i = 0; i < rd.size() && i < exp_rdat.size(); i++) begin
      chk($sformatf("%s.rdat%0d", name, i), rd[i], exp_rdat[i]);
      chk($sformatf("%s.rovf%0d", name, i), ro[i], exp_rovf[i]);
      chk($sformatf("%s.rcyc%0d", name, i), rc[i], exp_rcyc[i]);
    end
    chk($sformatf("%s.err", name), int'(err_o), exp_err);
    @(negedge clk);
    chk($sformatf("%s.busy_end", name), int'(busy_o), 0);
    chk($sformatf("%s.rv_end", name), int'(res_valid_o), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst         = 1'b1;
    prog_we_i   = 1'b0;
    prog_addr_i = '0;
    prog_op_i   = '0;
    prog_data_i = '0;
    prog_len_i  = '0;
    start_i     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", int'(busy_o), 0);
    chk("rst.done", int'(done_o), 0);
    chk("rst.rv", int'(res_valid_o), 0);
    chk("rst.err", int'(err_o), 0);
    chk("rst.op", int'(alu_if.alu_opcode), 0);
    chk("rst.rdat", int'(res_data_o), 0);
    rst = 1'b0;

    clear_prog();
    setp(0, 3'b110, 3); setp(1, 3'b110, 2); setp(2, 3'b100, 0);
    run_prog(3, 1'b1, "add");
    run_prog(3, 1'b0, "rerun");

    do_reset(); clear_prog();
    setp(0, 3'b110, 5); setp(1, 3'b110, 4); setp(2, 3'b100, 0);
    run_prog(3, 1'b1, "addovf");

    do_reset(); clear_prog();
    setp(0, 3'b110, 3); setp(1, 3'b110, 3); setp(2, 3'b101, 0); setp(3, 3'b111, 0);
    run_prog(4, 1'b1, "mulpop");

    do_reset(); clear_prog();
    setp(0, 3'b110, 1); setp(1, 3'b111, 0);
    run_prog(2, 1'b1, "badpop");
    run_prog(0, 1'b0, "len0");

    do_reset(); clear_prog();
    setp(0, 3'b110, 7); setp(1, 3'b110, 7); setp(2, 3'b100, 0);
    setp(3, 3'b110, 1); setp(4, 3'b110, 1); setp(5, 3'b101, 0);
    run_prog(6, 1'b1, "halt");

    do_reset();
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int k;
        k = $urandom_range(0, 9);
        case (k)
          4:       p_op[i] = 3'b111;
          5:       p_op[i] = 3'b100;
          6:       p_op[i] = 3'b101;
          7:       p_op[i] = 3'($urandom_range(0, 3));
          default: p_op[i] = 3'b110;
        endcase
        p_dat[i] = N'($urandom);
      end
      run_prog((r % 8 == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(1, 16)), 1'b1,
               $sformatf("rnd%0d", r));
    end

    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      p_op[i]  = 3'b110;
      p_dat[i] = N'($urandom);
    end
    load_prog();
    for (int r = 0; r < SDEPTH / DEPTH; r++) run_prog(DEPTH, 1'b0, $sformatf("fill%0d", r));
    clear_prog();
    setp(0, 3'b110, 1); setp(1, 3'b100, 0); setp(2, 3'b111, 0);
    run_prog(3, 1'b1, "full");

    do_reset(); clear_prog();
    setp(0, 3'b110, 1); setp(1, 3'b110, 2);
    for (int i = 2; i < 10; i++) setp(i, (i % 2 == 0) ? 3'b100 : 3'b101, 0);
    load_prog();
    @(negedge clk);
    start_i    = 1'b1;
    prog_len_i = 5'd10;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", int'(busy_o), 0);
    chk("abort.op", int'(alu_if.alu_opcode), 0);
    @(negedge clk);
    rst = 1'b0;
    ref_stk.delete();
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_valid_o) pulses++;
    end
    chk("abort.pulses", pulses, 0);
    chk("abort.op_idle", int'(alu_if.alu_opcode), 0);

    clear_prog();
    setp(0, 3'b110, 2); setp(1, 3'b110, 6); setp(2, 3'b101, 0);
    run_prog(3, 1'b1, "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
